// File: rtl/fx2_pkg.sv
// Shared types and sizing helpers for the FX2 stream packer.
// Defining FX2_PKTEND_EN adds the PKTEND serialiser state.
package fx2_pkg;

    localparam int unsigned OVF_WIDTH = 16;

`ifdef FX2_PKTEND_EN
    typedef enum logic [1:0] {IDLE, SEND, PKTEND} ser_state_t;
`else
    typedef enum logic [0:0] {IDLE, SEND} ser_state_t;
`endif

    function automatic int unsigned byte_idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int unsigned pkt_cnt_width(input int unsigned p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/fx2_word_fifo.sv
// Single-clock word FIFO with registered full/empty flags.
module fx2_word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_n;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (do_wr && !do_rd)
            count_n = count + 1'b1;
        else if (do_rd && !do_wr)
            count_n = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            full  <= (count_n == (AW + 1)'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fx2_stream_packer.sv
// Buffers multi-channel sample words and writes them LSB-first as bytes to the FX2 slave FIFO.
// Optional short-packet commit (PKTEND) is enabled by defining FX2_PKTEND_EN.
module fx2_stream_packer
    import fx2_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned PKT_BYTES    = 512
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0]   in_data,
    input  logic                             in_valid,
    input  logic                             flush,
    input  logic                             fx2_full_n,
    output logic [7:0]                       fx2_fd,
    output logic                             fx2_slwrn,
    output logic                             fx2_pktendn,
    output logic [OVF_WIDTH-1:0]             ovf_count,
    output logic                             busy
);

    localparam int unsigned DW     = NUM_CH * SAMPLE_WIDTH;
    localparam int unsigned W      = DW / 8;
    localparam int unsigned KW     = byte_idx_width(W);
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    ser_state_t           state, state_n;
    logic [W-1:0][7:0]    shreg;
    logic [KW-1:0]        k;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DW-1:0]        fifo_dout;
    logic                 fifo_wr;

`ifdef FX2_PKTEND_EN
    localparam int unsigned PW = pkt_cnt_width(PKT_BYTES);
    localparam logic [PW-1:0] PKT_LAST = PW'(PKT_BYTES - 1);
    logic [PW-1:0] pkt_bytes;
    logic          flush_pend;
    logic          flush_done;
`else
    logic          unused_flush;
    assign unused_flush = flush;
    assign fx2_pktendn  = 1'b1;
`endif

    assign fifo_wr = in_valid && enable && !fifo_full;

    fx2_word_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
`ifdef FX2_PKTEND_EN
        flush_done = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty && fx2_full_n) begin
                    pop     = 1'b1;
                    state_n = SEND;
                end
`ifdef FX2_PKTEND_EN
                else if (flush_pend && fifo_empty) begin
                    // Nothing buffered: commit only if the packet is partially filled.
                    flush_done = 1'b1;
                    if (pkt_bytes != '0) state_n = PKTEND;
                end
`endif
            end
            SEND: begin
                if (k == K_LAST) begin
                    if (!fifo_empty && fx2_full_n) pop = 1'b1;
                    else                           state_n = IDLE;
                end
            end
`ifdef FX2_PKTEND_EN
            PKTEND: state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the state, so bus activity trails the FSM by one clock.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg     <= '0;
            k         <= '0;
            fx2_fd    <= '0;
            fx2_slwrn <= 1'b1;
            busy      <= 1'b0;
            ovf_count <= '0;
        end else begin
            if (pop) begin
                shreg <= fifo_dout;
                k     <= '0;
            end else if (state == SEND) begin
                k <= k + 1'b1;
            end
            if (state == SEND) fx2_fd <= shreg[k];
            fx2_slwrn <= (state != SEND);
            busy      <= !fifo_empty || (state != IDLE);
            if (in_valid && enable && fifo_full && ovf_count != '1)
                ovf_count <= ovf_count + 1'b1;
        end
    end

`ifdef FX2_PKTEND_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pkt_bytes   <= '0;
            flush_pend  <= 1'b0;
            fx2_pktendn <= 1'b1;
        end else begin
            if (state == SEND)
                pkt_bytes <= (pkt_bytes == PKT_LAST) ? '0 : pkt_bytes + 1'b1;
            else if (state == PKTEND)
                pkt_bytes <= '0;
            if (flush)           flush_pend <= 1'b1;
            else if (flush_done) flush_pend <= 1'b0;
            fx2_pktendn <= (state != PKTEND);
        end
    end
`endif

endmodule

// File: tb/tb_fx2_stream_packer.sv
// Directed and randomized checks of fx2_stream_packer against a byte-queue reference model.
`timescale 1ns/1ps
module tb_fx2_stream_packer;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned SW     = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PKT    = 16;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        enable     = 1'b1;
    logic [31:0] in_data    = '0;
    logic        in_valid   = 1'b0;
    logic        flush      = 1'b0;
    logic        fx2_full_n = 1'b1;
    logic [7:0]  fx2_fd;
    logic        fx2_slwrn;
    logic        fx2_pktendn;
    logic [15:0] ovf_count;
    logic        busy;

    fx2_stream_packer #(
        .NUM_CH       (NUM_CH),
        .SAMPLE_WIDTH (SW),
        .FIFO_DEPTH   (DEPTH),
        .PKT_BYTES    (PKT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .flush       (flush),
        .fx2_full_n  (fx2_full_n),
        .fx2_fd      (fx2_fd),
        .fx2_slwrn   (fx2_slwrn),
        .fx2_pktendn (fx2_pktendn),
        .ovf_count   (ovf_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    byte unsigned exp_q[$];
    int          bytes_seen  = 0;
    int          run         = 0;
    int          max_run     = 0;
    int          pktend_cnt  = 0;
    int unsigned last_byte_cyc = 0;
    int unsigned pktend_cyc    = 0;
    int          model_bytes = 0;
    int          exp_ovf     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every byte strobed onto FD must be the next byte the model expects.
    always @(negedge clk) begin
        if (!reset_n) begin
            run = 0;
        end else begin
            if (!fx2_slwrn) begin
                run++;
                if (run > max_run) max_run = run;
                bytes_seen++;
                last_byte_cyc = cyc;
                if (exp_q.size() == 0) chk("spurious_slwr", 32'(fx2_slwrn), 32'd1);
                else                   chk("fd_byte", 32'(fx2_fd), 32'(exp_q.pop_front()));
            end else begin
                run = 0;
            end
            if (!fx2_pktendn) begin
                pktend_cnt++;
                pktend_cyc = cyc;
                chk("pktend_slwr_high", 32'(fx2_slwrn), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic en, input logic acc);
        in_valid = 1'b1;
        in_data  = d;
        enable   = en;
        if (acc) begin
            for (int b = 0; b < 4; b++) exp_q.push_back(d[8*b +: 8]);
            model_bytes += 4;
        end
        tick();
        in_valid = 1'b0;
        enable   = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        model_bytes = 0;
        exp_ovf     = 0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        fx2_full_n  = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic flush_and_check(input string tag);
        int snap;
        int exp_strobe;
        snap = pktend_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_drain(tag);
        repeat (6) tick();
        exp_strobe = 0;
`ifdef FX2_PKTEND_EN
        if ((model_bytes % PKT) != 0) begin
            exp_strobe  = 1;
            model_bytes = 0;
        end
`endif
        chk({tag, "_strobes"}, pktend_cnt - snap, exp_strobe);
        if (exp_strobe == 1) begin
            chk({tag, "_after_last"}, 32'(pktend_cyc > last_byte_cyc), 32'd1);
            chk({tag, "_soon"}, 32'(pktend_cyc - last_byte_cyc <= 3), 32'd1);
        end
        chk({tag, "_pktendn_idle"}, 32'(fx2_pktendn), 32'd1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int n;
        logic en;

        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_slwrn",   32'(fx2_slwrn),   32'd1);
        chk("rst_pktendn", 32'(fx2_pktendn), 32'd1);
        chk("rst_fd",      32'(fx2_fd),      32'd0);
        chk("rst_ovf",     32'(ovf_count),   32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        reset_n = 1'b1;
        tick();

        // Single word: first byte two clocks after acceptance, four strobes.
        push(32'hA1B2C3D4, 1'b1, 1'b1);
        chk("lat_n_slwrn", 32'(fx2_slwrn), 32'd1);
        tick();
        chk("lat_n1_slwrn", 32'(fx2_slwrn), 32'd1);
        tick();
        chk("lat_b0_slwrn", 32'(fx2_slwrn), 32'd0);
        chk("lat_b0_fd",    32'(fx2_fd),    32'hD4);
        repeat (3) tick();
        chk("lat_b3_slwrn", 32'(fx2_slwrn), 32'd0);
        chk("lat_b3_fd",    32'(fx2_fd),    32'hA1);
        tick();
        chk("lat_end_slwrn", 32'(fx2_slwrn), 32'd1);
        wait_drain("lat");

        // Eight words at the sustained rate stream without gaps.
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            push($urandom, 1'b1, 1'b1);
            repeat (3) tick();
        end
        wait_drain("burst");
        chk("burst_run", max_run, 32'd32);

        // FX2 full during byte 1 of word 0: word 0 finishes, word 1 waits.
        push($urandom, 1'b1, 1'b1);
        push($urandom, 1'b1, 1'b1);
        tick();
        tick();
        fx2_full_n = 1'b0;
        repeat (10) tick();
        chk("hold_pending", exp_q.size(), 32'd4);
        chk("hold_busy", 32'(busy), 32'd1);
        fx2_full_n = 1'b1;
        wait_drain("hold");

        // Overflow: depth-4 FIFO, six words while blocked.
        fx2_full_n = 1'b0;
        for (int i = 0; i < 6; i++) push($urandom, 1'b1, (i < 4));
        exp_ovf += 2;
        tick();
        chk("ovf_count", 32'(ovf_count), 32'(exp_ovf));
        push($urandom, 1'b0, 1'b0);
        tick();
        chk("ovf_disabled", 32'(ovf_count), 32'(exp_ovf));
        snap = bytes_seen;
        fx2_full_n = 1'b1;
        wait_drain("ovf");
        chk("ovf_bytes_out", bytes_seen - snap, 32'd16);

        // Random words, random gaps, occasional disabled input.
        for (int i = 0; i < 40; i++) begin
            en = ($urandom_range(0, 7) != 0);
            push($urandom, en, en);
            repeat ($urandom_range(3, 7)) tick();
        end
        wait_drain("rand");
        chk("rand_ovf", 32'(ovf_count), 32'(exp_ovf));

        // Reset in the middle of a word.
        push($urandom, 1'b1, 1'b1);
        n = 0;
        while (fx2_slwrn && n < 20) begin
            tick();
            n++;
        end
        chk("mid_started", 32'(fx2_slwrn), 32'd0);
        tick();
        reset_n = 1'b0;
        exp_q.delete();
        tick();
        chk("mid_rst_slwrn", 32'(fx2_slwrn), 32'd1);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_ovf",   32'(ovf_count), 32'd0);
        chk("mid_rst_fd",    32'(fx2_fd),    32'd0);
        reset_n     = 1'b1;
        exp_ovf     = 0;
        model_bytes = 0;
        snap = bytes_seen;
        repeat (10) tick();
        chk("mid_quiet", bytes_seen - snap, 32'd0);

        // Short-packet commit after 12 bytes, then a flush with nothing pending.
        do_reset();
        for (int i = 0; i < 3; i++) push($urandom, 1'b1, 1'b1);
        flush_and_check("pkt12");
        flush_and_check("pkt_empty");

        // Exactly one full packet: counter wrapped, so no strobe.
        do_reset();
        for (int i = 0; i < 4; i++) push($urandom, 1'b1, 1'b1);
        flush_and_check("pkt_full");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fx2_stream_packer.md
# fx2_stream_packer

Parametrised sample-stream-to-FX2 slave-FIFO writer: accepts multi-channel sample words from the DSP chain (CIC/FIR outputs), buffers them in a word FIFO, and serialises them LSB-first as bytes onto the FX2LP 8-bit FD bus with SLWR strobes. Successor to the fixed 2×16-bit byte sequencer: width and channel count are parametrised, back-to-back words stream without idle gaps, input overruns are counted rather than silently lost, and short-packet commit (PKTEND) is optional. It sits between the decimation filters and the FX2 pins in the top level.

## Interface
- NUM_CH, 2, channels per sample word (1..4)
- SAMPLE_WIDTH, 16, bits per channel; multiple of 8 (8..32)
- FIFO_DEPTH, 16, word FIFO depth; power of 2, ≥4
- PKT_BYTES, 512, FX2 endpoint packet size; multiple of W = NUM_CH*SAMPLE_WIDTH/8
- clk  in  1  block clock (IFCLK domain; top level may feed inverted IFCLK)
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  1 = accept input words; 0 = drop silently (no overflow count), drain continues
- in_data  in  NUM_CH*SAMPLE_WIDTH  {chN-1,…,ch0}; ch0 in LSBs
- in_valid  in  1  one-cycle word strobe; no backpressure
- flush  in  1  request short-packet commit (used only with PKTEND feature)
- fx2_full_n  in  1  FX2 FIFO not-full flag (FLAGN[1])
- fx2_fd  out  8  byte to FD pins
- fx2_slwrn  out  1  write strobe, active low
- fx2_pktendn  out  1  packet-end strobe, active low
- ovf_count  out  16  saturating count of words dropped on full FIFO
- busy  out  1  FIFO non-empty or serialiser not IDLE

## Operation
- Input: word written when in_valid & enable & !full. in_valid & enable & full → word dropped, ovf_count += 1, saturates at 16'hFFFF. full is the registered flag; a same-cycle pop does not rescue the incoming word.
- Serialiser states: IDLE, SEND, PKTEND.
- IDLE → SEND when FIFO non-empty and fx2_full_n = 1: pop word into shift register, byte index k = 0.
- SEND: each cycle drive byte k (bits [8k+7:8k]) on fx2_fd with fx2_slwrn = 0; k increments. On k = W-1: if FIFO non-empty and fx2_full_n = 1, pop next word, stay SEND with k = 0 (no gap); else → IDLE.
- fx2_full_n sampled only at word start; never aborts mid-word. PKT_BYTES multiple of W guarantees words never straddle packets.
- pkt_bytes counter increments per byte, wraps to 0 at PKT_BYTES.
- PKTEND state: see Configuration.
- Reset mid-word: partial word discarded, FIFO emptied, counters cleared.

## Timing
- Reset values: fx2_fd = 8'h00, fx2_slwrn = 1, fx2_pktendn = 1, ovf_count = 0, busy = 0, state IDLE, pkt_bytes = 0, flush-pending = 0.
- All outputs registered. Word accepted at edge N into empty FIFO with fx2_full_n = 1 → byte 0 on fx2_fd with fx2_slwrn = 0 after edge N+2; byte W-1 after edge N+W+1.
- Sustained throughput: 1 byte/clk while FIFO non-empty and fx2_full_n = 1; input rate must average ≤ 1 word per W clocks.
- fx2_slwrn low exactly W consecutive cycles per word; fx2_fd stable for each low cycle.
- fx2_full_n falling mid-word: current word completes; next word waits in IDLE until fx2_full_n = 1.

## Configuration
- FX2_PKTEND_EN defined: flush sets flush-pending (sticky). When flush-pending, state IDLE and FIFO empty: if pkt_bytes ≠ 0 → PKTEND for one cycle (fx2_pktendn = 0, fx2_slwrn = 1), pkt_bytes ← 0, flush-pending ← 0, → IDLE; if pkt_bytes = 0 → flush-pending cleared, no strobe (no zero-length packets). Words arriving before drain completes are sent first.
- Not defined: fx2_pktendn tied 1, flush ignored, PKTEND state absent.

## Structure
- Package fx2_pkg: serialiser state enum, byte-index/packet-counter width functions ($clog2 of W and PKT_BYTES), OVF_WIDTH = 16.
- Sub-module fx2_word_fifo: synchronous single-clock FIFO, registered full/empty, parametrised width/depth.

## Test plan
- NUM_CH=2, SAMPLE_WIDTH=16, word 32'hA1B2C3D4 → FD bytes D4,C3,B2,A1 with SLWRN low 4 cycles, first byte 2 clk after accept.
- 8 words every 4 clk, fx2_full_n = 1 → 32 contiguous SLWRN-low cycles, no gap, byte order preserved.
- fx2_full_n dropped during byte 1 of word 0 → word 0 completes, word 1 held until fx2_full_n = 1, no lost bytes.
- FIFO_DEPTH=4, fx2_full_n = 0, 6 words → 4 buffered, ovf_count = 2; release → exactly 4 words out.
- FX2_PKTEND_EN, 3 words (12 bytes) then flush → one PKTENDN-low cycle after last byte; second flush with pkt_bytes = 0 → no strobe.
- Reset asserted mid-word → next edge SLWRN = 1, busy = 0, ovf_count = 0.
